// File: rtl/debug_scan_pkg.sv
// Shared types and defaults for the debug-slave scan master and its bench.
package debug_scan_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UIR  = 3'd1,
    CDR  = 3'd2,
    SDR  = 3'd3,
    UDR  = 3'd4,
    RTI  = 3'd5,
    RESP = 3'd6
  } scan_state_t;

  localparam int DEBUG_DR_WIDTH = 38;
  localparam int DEBUG_IR_WIDTH = 2;

  // Debug-slave instruction opcodes
  localparam logic [DEBUG_IR_WIDTH-1:0] IR_NOP   = 2'd0;
  localparam logic [DEBUG_IR_WIDTH-1:0] IR_READ  = 2'd1;
  localparam logic [DEBUG_IR_WIDTH-1:0] IR_WRITE = 2'd2;
  localparam logic [DEBUG_IR_WIDTH-1:0] IR_CTRL  = 2'd3;

endpackage

// File: rtl/debug_scan_tck_gen.sv
// Divides clk into the scan clock and flags the tck rise event and period end.
module debug_scan_tck_gen #(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck,
  output logic rise,
  output logic period_end
);

  localparam int CW   = $clog2(TCK_DIV);
  localparam int HALF = TCK_DIV / 2;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;

  // tck is registered from the next count so the scan clock never glitches
  always_comb begin
    cnt_d = '0;
    if (en && (cnt_q != CW'(TCK_DIV - 1))) begin
      cnt_d = cnt_q + CW'(1);
    end
    tck_d = (cnt_d >= CW'(HALF));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck        = tck_q;
  assign rise       = en && (cnt_q == CW'(HALF - 1));
  assign period_end = en && (cnt_q == CW'(TCK_DIV - 1));

endmodule

// File: rtl/debug_scan_master.sv
// Host-side virtual-JTAG scan initiator: one command becomes a full
// update-IR / capture-DR / shift-DR / update-DR / run-test-idle sequence.
module debug_scan_master
  import debug_scan_pkg::*;
#(
  parameter int DR_WIDTH = DEBUG_DR_WIDTH,
  parameter int IR_WIDTH = DEBUG_IR_WIDTH,
  parameter int TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam int BCW = $clog2(DR_WIDTH + 1);

  scan_state_t         state_q, state_d;
  logic [DR_WIDTH-1:0] sr_q, sr_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
  logic                tdi_q, tdi_d;
  logic                tck_en, tck_rise, tck_end;

  assign tck_en = (state_q != IDLE) && (state_q != RESP);

  debug_scan_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk        (clk),
    .reset      (reset),
    .en         (tck_en),
    .tck        (tck),
    .rise       (tck_rise),
    .period_end (tck_end)
  );

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    ir_d      = ir_q;
    bit_cnt_d = bit_cnt_q;
    tdi_d     = tdi_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          ir_d    = cmd_ir;
          sr_d    = cmd_data;
          state_d = UIR;
        end
      end
      UIR: if (tck_end) state_d = CDR;
      CDR: begin
        if (tck_end) begin
          state_d   = SDR;
          bit_cnt_d = '0;
          tdi_d     = sr_q[0];
        end
      end
      SDR: begin
        if (tck_rise) sr_d = {tdo, sr_q[DR_WIDTH-1:1]};
        // tdi is reloaded only at period end so it is stable while tck is high
        if (tck_end) begin
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == BCW'(DR_WIDTH - 1)) begin
            state_d = UDR;
            tdi_d   = 1'b0;
          end else begin
            tdi_d = sr_q[0];
          end
        end
      end
      UDR: if (tck_end) state_d = RTI;
      RTI: if (tck_end) state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      bit_cnt_q <= '0;
      tdi_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      bit_cnt_q <= bit_cnt_d;
      tdi_q     <= tdi_d;
    end
  end

  // Shift data needs no reset: it is only visible through rsp_data in RESP
  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  assign rsp_data       = (state_q == RESP) ? sr_q : '0;
  assign tdi            = tdi_q;
  assign ir_in          = ir_q;
  assign vs_uir         = (state_q == UIR);
  assign vs_cdr         = (state_q == CDR);
  assign vs_sdr         = (state_q == SDR);
  assign vs_udr         = (state_q == UDR);
  assign jtag_state_rti = (state_q == IDLE) || (state_q == RTI);

endmodule

// File: tb/tb_debug_scan_master.sv
// Directed scoreboard bench for debug_scan_master (default and small instances).
module tb_debug_scan_master;
  import debug_scan_pkg::*;

  localparam int DRW = 38;
  localparam int SDRW = 8;
  localparam logic [63:0] MASK38 = (64'd1 << 38) - 64'd1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // default instance
  logic           reset, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [1:0]     cmd_ir, ir_in;
  logic [DRW-1:0] cmd_data, rsp_data;
  logic           tck, tdi, tdo, vs_uir, vs_cdr, vs_sdr, vs_udr, rti;

  debug_scan_master dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in),
    .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
    .jtag_state_rti(rti)
  );

  // small instance
  logic            s_reset, s_cmd_valid, s_cmd_ready, s_rsp_valid, s_rsp_ready;
  logic [1:0]      s_cmd_ir, s_ir_in;
  logic [SDRW-1:0] s_cmd_data, s_rsp_data;
  logic            s_tck, s_tdi, s_tdo, s_vs_uir, s_vs_cdr, s_vs_sdr, s_vs_udr, s_rti;

  debug_scan_master #(.DR_WIDTH(SDRW), .IR_WIDTH(2), .TCK_DIV(2)) dut_s (
    .clk(clk), .reset(s_reset), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_ir(s_cmd_ir), .cmd_data(s_cmd_data), .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
    .rsp_data(s_rsp_data), .tck(s_tck), .tdi(s_tdi), .tdo(s_tdo), .ir_in(s_ir_in),
    .vs_uir(s_vs_uir), .vs_cdr(s_vs_cdr), .vs_sdr(s_vs_sdr), .vs_udr(s_vs_udr),
    .jtag_state_rti(s_rti)
  );

  // tdo sources: 0 = tied low, 1 = tdi looped back one tck period late, 2 = tied high
  int         tdo_mode = 0;
  logic [3:0] tdi_hist = '0;
  always @(negedge clk) tdi_hist <= {tdi_hist[2:0], tdi};
  assign tdo = (tdo_mode == 1) ? tdi_hist[3] : (tdo_mode == 2);

  // small instance: present pattern LSB first, advancing after each tck rise in SDR
  logic [SDRW-1:0] s_pat = 8'h96;
  int              s_idx = 0;
  logic            s_tck_prev = 1'b0;
  always @(negedge clk) begin
    s_tck_prev <= s_tck;
    if (!s_vs_sdr) s_idx <= 0;
    else if (s_tck && !s_tck_prev) s_idx <= s_idx + 1;
  end
  assign s_tdo = s_pat[s_idx[2:0]];

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  int t_acc, lat;
  logic [1:0] cur_ir;
  int n_uir, n_cdr, n_sdr, n_udr, n_rti, n_rise, ir_bad, excl_bad, tdi_bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_tck"}, tck, 0);
    chk({t, "_tdi"}, tdi, 0);
    chk({t, "_ir_in"}, ir_in, 0);
    chk({t, "_vs"}, {vs_uir, vs_cdr, vs_sdr, vs_udr}, 0);
    chk({t, "_rti"}, rti, 1);
    chk({t, "_cmd_ready"}, cmd_ready, 1);
    chk({t, "_rsp_valid"}, rsp_valid, 0);
    chk({t, "_rsp_data"}, rsp_data, 0);
  endtask

  // called at a negedge in IDLE; returns at the negedge of the first UIR cycle
  task automatic send(input logic [1:0] ir, input logic [DRW-1:0] data, input logic [63:0] exp);
    cmd_valid = 1'b1;
    cmd_ir    = ir;
    cmd_data  = data;
    cur_ir    = ir;
    t_acc     = cyc;
    exp_q.push_back(exp);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("accept_uir", vs_uir, 1);
  endtask

  task automatic run_scan(input int max_cyc);
    logic prev_tck, prev_tdi;
    n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0; n_rise = 0;
    ir_bad = 0; excl_bad = 0; tdi_bad = 0; lat = -1;
    prev_tck = 1'b0; prev_tdi = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      if (rsp_valid) begin
        lat = cyc - t_acc;
        break;
      end
      if (vs_uir) n_uir++;
      if (vs_cdr) n_cdr++;
      if (vs_sdr) n_sdr++;
      if (vs_udr) n_udr++;
      if (rti) n_rti++;
      if (vs_uir && (ir_in !== cur_ir)) ir_bad++;
      if ((int'(vs_uir) + int'(vs_cdr) + int'(vs_sdr) + int'(vs_udr) + int'(rti)) > 1) excl_bad++;
      if (vs_sdr && tck && !prev_tck) n_rise++;
      if (tck && (tdi !== prev_tdi)) tdi_bad++;
      prev_tck = tck;
      prev_tdi = tdi;
      @(negedge clk);
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_hs_rsp_valid", rsp_valid, 0);
    chk("post_hs_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    logic [63:0]    e;
    logic [DRW-1:0] d;
    int             saw;
    reset = 1'b1; cmd_valid = 1'b0; cmd_ir = '0; cmd_data = '0; rsp_ready = 1'b0;
    s_reset = 1'b1; s_cmd_valid = 1'b0; s_cmd_ir = '0; s_cmd_data = '0; s_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    reset = 1'b0; s_reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_cmd_ready", cmd_ready, 1);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_tck", tck, 0);
      chk("idle_rti", rti, 1);
    end

    // reset in the middle of shift-DR aborts without a response
    send(IR_WRITE, 38'h15_5555_5555, 64'd0);
    repeat (59) @(negedge clk);
    chk("abort_in_sdr", vs_sdr, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset("abort");
    reset = 1'b0;
    void'(exp_q.pop_back());
    saw = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) saw++;
    end
    chk("abort_no_rsp", saw, 0);

    // loopback: response is the command data delayed by one bit
    tdo_mode = 1;
    d = 38'h2A_5A5A_5A5A;
    send(IR_READ, d, ({26'd0, d} << 1) & MASK38);
    run_scan(400);
    chk("loop_latency", lat, 169);
    chk("loop_ir_in_uir", ir_bad, 0);
    chk("seq_uir_cycles", n_uir, 4);
    chk("seq_cdr_cycles", n_cdr, 4);
    chk("seq_sdr_cycles", n_sdr, 152);
    chk("seq_udr_cycles", n_udr, 4);
    chk("seq_rti_cycles", n_rti, 4);
    chk("seq_exclusive", excl_bad, 0);
    chk("seq_tdi_stable_tck_high", tdi_bad, 0);
    chk("loop_rsp_data", rsp_data, exp_q.pop_front());
    release_rsp();

    // tdo tied high, zero data in
    tdo_mode = 2;
    send(IR_WRITE, '0, 64'h3F_FFFF_FFFF);
    run_scan(400);
    chk("ones_latency", lat, 169);
    chk("ones_sdr_rises", n_rise, 38);
    e = exp_q.pop_front();
    chk("ones_rsp_data", rsp_data, e);

    // backpressure with the next command already offered
    tdo_mode  = 0;
    cmd_valid = 1'b1;
    cmd_ir    = IR_CTRL;
    cmd_data  = 38'h00_0000_0001;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, e);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_hs_rsp_valid", rsp_valid, 0);
    chk("bp_next_cmd_ready", cmd_ready, 1);
    t_acc  = cyc;
    cur_ir = IR_CTRL;
    exp_q.push_back(64'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_next_accept_uir", vs_uir, 1);
    chk("bp_next_ir_in", ir_in, 2'b11);
    run_scan(400);
    chk("bp_next_latency", lat, 169);
    chk("bp_next_ir_uir", ir_bad, 0);
    chk("bp_next_rsp_data", rsp_data, exp_q.pop_front());
    release_rsp();

    // small instance: TCK_DIV=2, DR_WIDTH=8
    s_cmd_valid = 1'b1;
    s_cmd_ir    = IR_READ;
    s_cmd_data  = 8'hC3;
    t_acc       = cyc;
    exp_q.push_back(64'h96);
    @(negedge clk);
    s_cmd_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      if (s_rsp_valid) begin
        lat = cyc - t_acc;
        break;
      end
      @(negedge clk);
    end
    chk("small_latency", lat, 25);
    chk("small_rsp_data", s_rsp_data, exp_q.pop_front());
    chk("small_ir_in", s_ir_in, IR_READ);
    s_rsp_ready = 1'b1;
    @(negedge clk);
    s_rsp_ready = 1'b0;
    chk("small_post_hs_ready", s_cmd_ready, 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
